// File: rtl/bombman_pkg.sv
// Shared definitions for the game-end arbiter: winner codes, FSM states and
// the counter-width helper used by every frame counter.
package bombman_pkg;

    localparam logic [1:0] WIN_P1   = 2'd0;
    localparam logic [1:0] WIN_P2   = 2'd1;
    localparam logic [1:0] WIN_DRAW = 2'd2;
    localparam logic [1:0] WIN_NONE = 2'd3;

    typedef enum logic [1:0] {
        PLAY         = 2'd0,
        GRACE        = 2'd1,
        SHOW         = 2'd2,
        WAIT_RESTART = 2'd3
    } game_state_t;

    // Width of a down-counter that must hold max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/game_end_arbiter_player_life_counter.sv
// One player's lives register, invulnerability window and hit-accept logic.
// o_lives_next exposes the value being loaded this cycle so the FSM can react without delay.
module player_life_counter
    import bombman_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hit,
    input  logic       i_enable,
    input  logic       i_tick,
    input  logic       i_reload,
    output logic [1:0] o_lives,
    output logic [1:0] o_lives_next
);

    localparam int                 INV_W      = cnt_width(INVULN_FRAMES);
    localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES);
    localparam logic [1:0]         LIVES_LOAD = 2'(LIVES);

    logic [1:0]       r_lives;
    logic [INV_W-1:0] r_invuln;
    logic [1:0]       w_lives_next;
    logic [INV_W-1:0] w_invuln_next;
    logic             w_accept;

    assign w_accept = i_enable && i_hit && (r_invuln == '0) && (r_lives != 2'd0);

    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_lives_next  = r_lives;
        w_invuln_next = r_invuln;
        if (i_reload) begin
            w_lives_next  = LIVES_LOAD;
            w_invuln_next = '0;
        end else if (w_accept) begin
            w_lives_next  = r_lives - 2'd1;
            w_invuln_next = INV_LOAD;
        end else if (i_tick && (r_invuln != '0)) begin
            w_invuln_next = r_invuln - INV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lives  <= LIVES_LOAD;
            r_invuln <= '0;
        end else begin
            r_lives  <= w_lives_next;
            r_invuln <= w_invuln_next;
        end
    end

    assign o_lives      = r_lives;
    assign o_lives_next = w_lives_next;

endmodule

// File: rtl/game_end_arbiter.sv
// Round controller: tracks both players' lives, resolves win/draw with a grace
// window, holds the end screen, then waits for a fresh restart press.
module game_end_arbiter
    import bombman_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int INVULN_FRAMES   = 60,
    parameter int GRACE_FRAMES    = 4,
    parameter int MIN_SHOW_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       restart_btn,
    output logic       game_over,
    output logic [1:0] which,
    output logic       freeze,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives
);

    localparam int               GR_W       = cnt_width(GRACE_FRAMES);
    localparam int               SH_W       = cnt_width(MIN_SHOW_FRAMES);
    localparam logic [GR_W-1:0]  GRACE_LOAD = GR_W'(GRACE_FRAMES);
    localparam logic [SH_W-1:0]  SHOW_LOAD  = SH_W'(MIN_SHOW_FRAMES);

    game_state_t     r_state;
    logic [GR_W-1:0] r_grace;
    logic [SH_W-1:0] r_show;
    logic            r_restart_d;
    logic [1:0]      r_which;
    logic            r_game_over;
    logic            r_freeze;

    logic            w_hits_enabled;
    logic            w_restart_edge;
    logic            w_reload;
    logic [1:0]      w_p1_lives_next;
    logic [1:0]      w_p2_lives_next;
    logic            w_p1_dead;
    logic            w_p2_dead;
    logic [GR_W-1:0] w_grace_next;
    logic [SH_W-1:0] w_show_next;

    assign w_hits_enabled = (r_state == PLAY) || (r_state == GRACE);
    assign w_restart_edge = restart_btn && !r_restart_d;
    assign w_reload       = (r_state == WAIT_RESTART) && w_restart_edge;
    assign w_p1_dead      = (w_p1_lives_next == 2'd0);
    assign w_p2_dead      = (w_p2_lives_next == 2'd0);
    assign w_grace_next   = (frame_tick && (r_grace != '0)) ? r_grace - GR_W'(1) : r_grace;
    assign w_show_next    = (frame_tick && (r_show != '0)) ? r_show - SH_W'(1) : r_show;

    player_life_counter #(
        .LIVES        (LIVES),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_p1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hit       (p1_hit),
        .i_enable    (w_hits_enabled),
        .i_tick      (frame_tick),
        .i_reload    (w_reload),
        .o_lives     (p1_lives),
        .o_lives_next(w_p1_lives_next)
    );

    player_life_counter #(
        .LIVES        (LIVES),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_p2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hit       (p2_hit),
        .i_enable    (w_hits_enabled),
        .i_tick      (frame_tick),
        .i_reload    (w_reload),
        .o_lives     (p2_lives),
        .o_lives_next(w_p2_lives_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= PLAY;
            r_grace     <= '0;
            r_show      <= '0;
            r_restart_d <= 1'b0;
            r_which     <= WIN_NONE;
            r_game_over <= 1'b0;
            r_freeze    <= 1'b0;
        end else begin
            // The delayed copy tracks every cycle, so presses during SHOW are consumed, not queued.
            r_restart_d <= restart_btn;
            case (r_state)
                PLAY: begin
                    if (w_p1_dead && w_p2_dead) begin
                        r_state     <= SHOW;
                        r_which     <= WIN_DRAW;
                        r_show      <= SHOW_LOAD;
                        r_game_over <= 1'b1;
                        r_freeze    <= 1'b1;
                    end else if (w_p1_dead || w_p2_dead) begin
                        r_state <= GRACE;
                        r_grace <= GRACE_LOAD;
                    end
                end
                GRACE: begin
                    if (w_p1_dead && w_p2_dead) begin
                        r_state     <= SHOW;
                        r_which     <= WIN_DRAW;
                        r_grace     <= '0;
                        r_show      <= SHOW_LOAD;
                        r_game_over <= 1'b1;
                        r_freeze    <= 1'b1;
                    end else if (w_grace_next == '0) begin
                        r_state     <= SHOW;
                        r_which     <= w_p2_dead ? WIN_P1 : WIN_P2;
                        r_grace     <= '0;
                        r_show      <= SHOW_LOAD;
                        r_game_over <= 1'b1;
                        r_freeze    <= 1'b1;
                    end else begin
                        r_grace <= w_grace_next;
                    end
                end
                SHOW: begin
                    r_show <= w_show_next;
                    if (w_show_next == '0) begin
                        r_state <= WAIT_RESTART;
                    end
                end
                WAIT_RESTART: begin
                    if (w_restart_edge) begin
                        r_state     <= PLAY;
                        r_which     <= WIN_NONE;
                        r_grace     <= '0;
                        r_show      <= '0;
                        r_game_over <= 1'b0;
                        r_freeze    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= PLAY;
                end
            endcase
        end
    end

    assign game_over = r_game_over;
    assign which     = r_which;
    assign freeze    = r_freeze;

endmodule

// File: tb/tb_game_end_arbiter.sv
// Directed bench for game_end_arbiter: expected status words are queued as stimulus
// is applied and popped when the DUT's registered outputs are sampled.
module tb_game_end_arbiter;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       p1_hit;
    logic       p2_hit;
    logic       restart_btn;
    logic       game_over;
    logic [1:0] which;
    logic       freeze;
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;

    game_end_arbiter #(
        .LIVES          (3),
        .INVULN_FRAMES  (60),
        .GRACE_FRAMES   (4),
        .MIN_SHOW_FRAMES(120)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .p1_hit     (p1_hit),
        .p2_hit     (p2_hit),
        .restart_btn(restart_btn),
        .game_over  (game_over),
        .which      (which),
        .freeze     (freeze),
        .p1_lives   (p1_lives),
        .p2_lives   (p2_lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Status word: {game_over, freeze, which, p1_lives, p2_lives}.
    task automatic expect_st(input string tag, input logic go, input logic [1:0] wh,
                             input logic [1:0] l1, input logic [1:0] l2);
        exp_t e;
        e.tag = tag;
        e.exp = {go, go, wh, l1, l2};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [7:0] obs;
        obs = {game_over, freeze, which, p1_lives, p2_lives};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hit(input logic a, input logic b);
        p1_hit = a;
        p2_hit = b;
        cycle();
        p1_hit = 1'b0;
        p2_hit = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_tick  = 1'b0;
        p1_hit      = 1'b0;
        p2_hit      = 1'b0;
        restart_btn = 1'b0;
        cycle();
        cycle();

        // Reset state
        expect_st("reset", 1'b0, 2'd3, 2'd3, 2'd3);
        do_reset();
        check();

        // P1 loses all three lives, hits spaced past the invulnerability window
        expect_st("p1_hit1", 1'b0, 2'd3, 2'd2, 2'd3);
        hit(1'b1, 1'b0);
        check();
        ticks(61);
        expect_st("p1_hit2", 1'b0, 2'd3, 2'd1, 2'd3);
        hit(1'b1, 1'b0);
        check();
        ticks(61);
        expect_st("p1_hit3_grace", 1'b0, 2'd3, 2'd0, 2'd3);
        hit(1'b1, 1'b0);
        check();
        ticks(3);
        expect_st("grace_3_ticks", 1'b0, 2'd3, 2'd0, 2'd3);
        check();
        expect_st("grace_expired_p2_wins", 1'b1, 2'd1, 2'd0, 2'd3);
        tick();
        check();

        // Hits ignored in SHOW
        expect_st("show_hit_ignored", 1'b1, 2'd1, 2'd0, 2'd3);
        hit(1'b0, 1'b1);
        check();

        // Restart press during SHOW is discarded
        ticks(49);
        restart_btn = 1'b1;
        cycle();
        restart_btn = 1'b0;
        expect_st("show_restart_ignored", 1'b1, 2'd1, 2'd0, 2'd3);
        cycle();
        check();
        ticks(70);
        expect_st("wait_restart_held", 1'b1, 2'd1, 2'd0, 2'd3);
        ticks(2);
        check();

        // Fresh press in WAIT_RESTART starts a new round one cycle later
        restart_btn = 1'b1;
        expect_st("restart_new_round", 1'b0, 2'd3, 2'd3, 2'd3);
        cycle();
        check();
        restart_btn = 1'b0;
        cycle();

        // Second P2 hit inside the invulnerability window is dropped
        expect_st("p2_hit1", 1'b0, 2'd3, 2'd3, 2'd2);
        hit(1'b0, 1'b1);
        check();
        ticks(10);
        expect_st("p2_hit_invuln_drop", 1'b0, 2'd3, 2'd3, 2'd2);
        hit(1'b0, 1'b1);
        check();

        // Simultaneous hits are accepted independently
        ticks(61);
        expect_st("both_hit_indep", 1'b0, 2'd3, 2'd2, 2'd1);
        hit(1'b1, 1'b1);
        check();
        ticks(61);
        expect_st("p1_to_one", 1'b0, 2'd3, 2'd1, 2'd1);
        hit(1'b1, 1'b0);
        check();
        ticks(61);
        expect_st("simul_death_draw", 1'b1, 2'd2, 2'd0, 2'd0);
        hit(1'b1, 1'b1);
        check();
        ticks(10);
        expect_st("draw_stable", 1'b1, 2'd2, 2'd0, 2'd0);
        check();

        // One-cycle reset mid-SHOW
        expect_st("reset_mid_show", 1'b0, 2'd3, 2'd3, 2'd3);
        do_reset();
        check();

        // P2 dies first; P1 dies within the grace window -> draw
        expect_st("both_to_two", 1'b0, 2'd3, 2'd2, 2'd2);
        hit(1'b1, 1'b1);
        check();
        ticks(61);
        expect_st("both_to_one", 1'b0, 2'd3, 2'd1, 2'd1);
        hit(1'b1, 1'b1);
        check();
        ticks(61);
        expect_st("p2_dies_grace", 1'b0, 2'd3, 2'd1, 2'd0);
        hit(1'b0, 1'b1);
        check();
        ticks(2);
        expect_st("grace_2_ticks", 1'b0, 2'd3, 2'd1, 2'd0);
        check();
        expect_st("late_death_draw", 1'b1, 2'd2, 2'd0, 2'd0);
        hit(1'b1, 1'b0);
        check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
